// File: rtl/multicycle_cpu_if.sv
// Instruction-memory fetch channel: req/addr from the core, ack/rdata from program memory.
interface multicycle_cpu_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: fetch/decode/execute/writeback FSM, register file, ALU and PC logic.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  FETCH      | imem_req high, wait for imem_ack, latch IR
//  DECODE     | read rs/rt into operand registers A/B
//  EXECUTE    | ALU op or branch compare; register alu_result and flags
//  WRITEBACK  | register write, pc update, instr_done pulse
//  HALT       | terminal; no fetch, pc frozen until reset
module multicycle_cpu #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_cpu_if.master     imem,
    output logic [PC_W-1:0]      pc,
    output logic [DATA_W-1:0]    alu_result,
    output logic                 NegativeFlag,
    output logic                 ZeroFlag,
    output logic                 instr_done,
    output logic                 halted
);
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SH_W   = $clog2(DATA_W);
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_HALT      = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_J    = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    logic [2:0]        state;
    logic              started;
    logic [31:0]       ir;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              take_br;
    logic [DATA_W-1:0] rf [NUM_REGS];

    logic              fetch_req;
    logic [3:0]        op;
    logic [RIDX_W-1:0] rs_idx;
    logic [RIDX_W-1:0] rt_idx;
    logic [RIDX_W-1:0] rd_idx;
    logic [RIDX_W-1:0] dest_idx;
    logic [31:0]       imm32;
    logic [31:0]       br_off32;
    logic [31:0]       jt32;
    logic [DATA_W-1:0] imm_d;
    logic [DATA_W-1:0] alu_out;
    logic              is_alu;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_next;
    logic              unused_bits;

    assign op       = ir[31:28];
    assign rs_idx   = ir[21 +: RIDX_W];
    assign rt_idx   = ir[16 +: RIDX_W];
    assign rd_idx   = ir[11 +: RIDX_W];
    assign dest_idx = (op == OP_ADDI) ? rt_idx : rd_idx;
    assign imm32    = {{16{ir[15]}}, ir[15:0]};
    assign br_off32 = imm32 << 2;
    assign jt32     = {4'b0000, ir[25:0], 2'b00};
    assign imm_d    = imm32[DATA_W-1:0];
    assign is_alu   = (op <= OP_ADDI);

    // started holds off imem_req until the first clock after reset release
    assign fetch_req      = started && (state == S_FETCH);
    assign imem.imem_req  = fetch_req;
    assign imem.imem_addr = pc;

    assign unused_bits = ^{ir, br_off32, jt32, imm32, opb};

    always_comb begin
        alu_out = '0;
        case (op)
            OP_ADD:  alu_out = opa + opb;
            OP_SUB:  alu_out = opa - opb;
            OP_AND:  alu_out = opa & opb;
            OP_OR:   alu_out = opa | opb;
            OP_XOR:  alu_out = opa ^ opb;
            OP_SLT:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
            OP_SLL:  alu_out = opa << opb[SH_W-1:0];
            OP_SRL:  alu_out = opa >> opb[SH_W-1:0];
            OP_ADDI: alu_out = opa + imm_d;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        pc_inc  = pc + PC_W'(4);
        pc_next = pc_inc;
        case (op)
            OP_BEQ, OP_BNE: pc_next = take_br ? (pc_inc + br_off32[PC_W-1:0]) : pc_inc;
            OP_J:           pc_next = jt32[PC_W-1:0];
            default:        pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            started      <= 1'b0;
            pc           <= RST_PC;
            ir           <= '0;
            opa          <= '0;
            opb          <= '0;
            take_br      <= 1'b0;
            alu_result   <= '0;
            NegativeFlag <= 1'b0;
            ZeroFlag     <= 1'b0;
            instr_done   <= 1'b0;
            halted       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            started    <= 1'b1;
            instr_done <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (fetch_req && imem.imem_ack) begin
                        ir    <= imem.imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa   <= (rs_idx == '0) ? '0 : rf[rs_idx];
                    opb   <= (rt_idx == '0) ? '0 : rf[rt_idx];
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    take_br <= (op == OP_BEQ) ? (opa == opb) : (opa != opb);
                    if (is_alu) begin
                        alu_result   <= alu_out;
                        NegativeFlag <= alu_out[DATA_W-1];
                        ZeroFlag     <= (alu_out == '0);
                    end
                    instr_done <= 1'b1;
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (is_alu && (dest_idx != '0)) rf[dest_idx] <= alu_result;
                    pc    <= pc_next;
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: ISA-level reference model, random-latency program memory, per-cycle checks.
module tb_multicycle_cpu;
    localparam int PC_W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pc;
    logic [31:0] alu_result;
    logic        nf, zf, instr_done, halted;

    always #5 clk = ~clk;

    multicycle_cpu_if #(.PC_W(PC_W)) imem ();

    multicycle_cpu #(.DATA_W(32), .NUM_REGS(32), .PC_W(PC_W), .RESET_PC(0)) dut (
        .clk(clk), .reset(rst_n), .imem(imem), .pc(pc), .alu_result(alu_result),
        .NegativeFlag(nf), .ZeroFlag(zf), .instr_done(instr_done), .halted(halted));

    logic [31:0] mem [64];
    int          n_cmp = 0, n_err = 0;
    int          min_wait = 0, max_wait = 0;
    logic [31:0] lit_pc [$];
    logic [31:0] lit_alu [$];

    // ISA-level architectural state
    logic [31:0] m_regs [32];
    logic [7:0]  m_pc;
    logic [31:0] m_alu;
    logic        m_n, m_z, m_halted;
    int          m_done_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ii(input int op, input int rs, input int rt, input logic [15:0] imm);
        ii = {op[3:0], 2'b00, rs[4:0], rt[4:0], imm};
    endfunction
    function automatic logic [31:0] rr(input int op, input int rs, input int rt, input int rd);
        rr = {op[3:0], 2'b00, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction
    function automatic logic [31:0] jj(input logic [25:0] a);
        jj = {4'd11, a, 2'b00} >> 2 | {4'd11, 28'd0};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = '0; m_alu = '0; m_n = 0; m_z = 0; m_halted = 0; m_done_cnt = 0;
    endtask

    task automatic m_step(input logic [31:0] ins);
        logic [3:0]  op;
        logic [31:0] a, b, r, simm;
        logic [4:0]  d;
        op   = ins[31:28];
        a    = m_regs[ins[25:21]];
        b    = m_regs[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        r    = '0;
        m_done_cnt++;
        if (op <= 4'd8) begin
            case (op)
                4'd0: r = a + b;
                4'd1: r = a - b;
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = a ^ b;
                4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd6: r = a << b[4:0];
                4'd7: r = a >> b[4:0];
                default: r = a + simm;
            endcase
            m_alu = r; m_n = r[31]; m_z = (r == 0);
            d = (op == 4'd8) ? ins[20:16] : ins[15:11];
            if (d != 0) m_regs[d] = r;
            m_pc = m_pc + 8'd4;
        end else if (op == 4'd9 || op == 4'd10) begin
            if ((a == b) == (op == 4'd9)) m_pc = m_pc + 8'd4 + 8'(simm * 4);
            else m_pc = m_pc + 8'd4;
        end else if (op == 4'd11) begin
            m_pc = 8'(ins[25:0] * 4);
        end else if (op == 4'd15) begin
            m_halted = 1'b1;
        end else begin
            m_pc = m_pc + 8'd4;
        end
    endtask

    // program memory: random wait states; ack with req low is random noise the DUT must ignore
    initial begin
        int fw;
        fw = -1;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                imem.imem_ack = 1'b0;
                fw = -1;
            end else if (imem.imem_req) begin
                if (fw < 0) fw = $urandom_range(max_wait, min_wait);
                if (fw == 0) begin
                    imem.imem_ack   = 1'b1;
                    imem.imem_rdata = mem[imem.imem_addr[7:2]];
                    fw = -1;
                end else begin
                    imem.imem_ack   = 1'b0;
                    imem.imem_rdata = $urandom;
                    fw--;
                end
            end else begin
                imem.imem_ack   = 1'($urandom_range(1, 0));
                imem.imem_rdata = $urandom;
                fw = -1;
            end
        end
    end

    // compare process
    initial begin
        int   cd;
        logic p_req, p_ack, p_done, exp_done, after_rst;
        logic [7:0] p_addr;
        cd = -1; p_req = 0; p_ack = 0; p_done = 0; p_addr = '0; after_rst = 0;
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_state", {imem.imem_req, instr_done, halted, nf, zf, pc, alu_result}, 64'd0);
                m_reset();
                cd = -1; p_req = 0; p_ack = 0; p_done = 0; after_rst = 1;
                continue;
            end
            if (after_rst) begin
                check("req_after_release", imem.imem_req, 1);
                check("addr_after_release", imem.imem_addr, 0);
                after_rst = 0;
            end
            exp_done = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    exp_done = 1;
                    cd = -1;
                end
            end
            check("instr_done", instr_done, exp_done);
            if (p_req && !p_ack) begin
                check("fetch_hold_req", imem.imem_req, 1);
                check("fetch_hold_addr", imem.imem_addr, p_addr);
            end
            if (p_done) check("refetch", imem.imem_req, !m_halted);
            else if (cd > 0 || exp_done || m_halted || (p_req && p_ack)) check("req_idle", imem.imem_req, 0);
            if (imem.imem_req && !p_req) check("fetch_addr", imem.imem_addr, m_pc);
            if (exp_done) begin
                check("retire_pc", pc, m_pc);
                if (lit_pc.size() > 0) check("lit_pc", pc, lit_pc.pop_front());
                m_step(mem[m_pc[7:2]]);
                check("alu_result", alu_result, m_alu);
                check("flags", {nf, zf}, {m_n, m_z});
                if (lit_alu.size() > 0) check("lit_alu", alu_result, lit_alu.pop_front());
            end
            check("halted", halted, m_halted);
            p_req  = imem.imem_req;
            p_ack  = imem.imem_ack;
            p_addr = imem.imem_addr;
            p_done = exp_done;
            if (imem.imem_req && imem.imem_ack) cd = 3;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic rst_assert();
        @(posedge clk);
        #3 rst_n = 1'b0;
    endtask

    task automatic rst_release();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_prog(input int sel);
        for (int i = 0; i < 64; i++) mem[i] = 32'hF000_0000;
        lit_pc.delete();
        lit_alu.delete();
        if (sel == 1) begin
            mem[0]  = ii(8, 0, 1, 16'd5);
            mem[1]  = ii(8, 0, 2, 16'hFFFD);
            mem[2]  = rr(0, 1, 2, 3);
            mem[3]  = rr(1, 1, 1, 4);
            mem[4]  = rr(5, 2, 1, 5);
            mem[5]  = ii(9, 0, 0, 16'd2);
            mem[8]  = ii(8, 0, 0, 16'd7);
            mem[9]  = rr(0, 0, 0, 6);
            mem[10] = ii(8, 1, 1, 16'hFFFF);
            mem[11] = ii(10, 1, 0, 16'hFFFE);
            lit_pc  = '{0, 4, 8, 12, 16, 20, 32, 36, 40, 44, 40, 44, 40, 44, 40, 44, 40, 44, 48};
            lit_alu = '{5, 32'hFFFF_FFFD, 2, 0, 1, 1, 7, 0, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0, 0};
        end else if (sel == 2) begin
            mem[0]  = ii(8, 1, 1, 16'd1);
            mem[1]  = ii(8, 1, 2, 16'hFFFE);
            mem[2]  = ii(9, 2, 0, 16'd1);
            mem[3]  = jj(26'h3F);
            mem[63] = 32'hC000_0000;
            lit_pc  = '{0, 4, 8, 12, 252, 0, 4, 8, 16};
            lit_alu = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0, 0};
        end else begin
            for (int i = 0; i < 64; i++) begin
                logic [31:0] ins;
                int op;
                ins = $urandom;
                op  = $urandom_range(14, 0);
                if ($urandom_range(19, 0) == 0) op = 15;
                ins[31:28] = op[3:0];
                ins[25:21] = 5'($urandom_range(7, 0));
                ins[20:16] = 5'($urandom_range(7, 0));
                if (op < 8) ins[15:11] = 5'($urandom_range(7, 0));
                mem[i] = ins;
            end
        end
    endtask

    task automatic run_to_end(input int max_dones, input int budget);
        int c;
        c = 0;
        while (!m_halted && m_done_cnt < max_dones && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("run_timeout", (c >= budget), 0);
        if (m_halted) repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), dut.rf[i], m_regs[i]);
        check("lit_left", lit_pc.size(), 0);
    endtask

    initial begin
        int c;
        // zero-wait directed program
        rst_assert(); load_prog(1); min_wait = 0; max_wait = 0; rst_release();
        run_to_end(100, 400);
        check("model_r2", m_regs[2], 32'hFFFF_FFFD);
        check("model_r3", m_regs[3], 32'd2);
        check("model_r5", m_regs[5], 32'd1);
        check("model_r0", m_regs[0], 32'd0);
        check("model_halt_pc", m_pc, 8'd48);

        // same program with 3 wait states on every fetch
        rst_assert(); load_prog(1); min_wait = 3; max_wait = 3; rst_release();
        run_to_end(100, 600);

        // J to 0xFC then NOP wraps pc to 0
        rst_assert(); load_prog(2); min_wait = 0; max_wait = 2; rst_release();
        run_to_end(100, 400);
        check("model_wrap_r1", m_regs[1], 32'd2);

        // reset in the middle of a waiting fetch at pc=12
        rst_assert(); load_prog(1); min_wait = 3; max_wait = 3; rst_release();
        c = 0;
        while (m_done_cnt < 3 && c < 100) begin @(posedge clk); c++; end
        while (!imem.imem_req && c < 100) begin @(posedge clk); c++; end
        check("midfetch_timeout", (c >= 100), 0);
        check("midfetch_addr", imem.imem_addr, 8'd12);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midfetch_pc", pc, 8'd0);
        check("midfetch_req", imem.imem_req, 0);
        load_prog(1); min_wait = 0; max_wait = 2;
        rst_release();
        run_to_end(100, 500);

        // random programs
        for (int r = 0; r < 6; r++) begin
            rst_assert(); load_prog(3);
            min_wait = 0; max_wait = $urandom_range(3, 0);
            rst_release();
            run_to_end(150, 150 * 8 + 50);
        end

        rst_assert();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
